alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_if.sv | 46 ++++
 rtl/alu_sequencer.sv | 165 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sequencer_if
//  Description : Request, ALU-side and response signals of the ALU sequencer.
//                The slave modport is the sequencer's view; the master modport
//                is the view of the surrounding logic (requester, ALU, sink).
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_sequencer_if;
    // Upstream request channel
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_op;
    logic [31:0] req_x;
    logic [31:0] req_y;
    // ALU drive and completion
    logic [4:0]  alu_op;
    logic [31:0] alu_x;
    logic [31:0] alu_y;
    logic        alu_done;
    logic [66:0] alu_result;
    logic [32:0] alu_remainder;
    // Downstream response channel
    logic        rsp_valid;
    logic        rsp_ready;
    logic [66:0] rsp_result;
    logic [32:0] rsp_remainder;
    logic        rsp_err;

    modport slave (
        input  req_valid, req_op, req_x, req_y,
        input  alu_done, alu_result, alu_remainder,
        input  rsp_ready,
        output req_ready, alu_op, alu_x, alu_y,
        output rsp_valid, rsp_result, rsp_remainder, rsp_err
    );

    modport master (
        output req_valid, req_op, req_x, req_y,
        output alu_done, alu_result, alu_remainder,
        output rsp_ready,
        input  req_ready, alu_op, alu_x, alu_y,
        input  rsp_valid, rsp_result, rsp_remainder, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sequencer
//  Description : Accepts one ALU request at a time, drives the ALU from
//                registers, waits for completion and holds the captured
//                result until the downstream accepts it. Invalid opcodes and
//                divide-by-zero are answered directly with an error response.
//  Config      : ALU_SEQ_TIMEOUT_EN - when defined, a WAIT that lasts TIMEOUT
//                cycles without alu_done is aborted with an error response.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer #(
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  alu_op_q, alu_op_d;
    logic [31:0] alu_x_q, alu_x_d;
    logic [31:0] alu_y_q, alu_y_d;
    logic        settle_q, settle_d;
    logic [66:0] res_q, res_d;
    logic [32:0] rem_q, rem_d;
    logic        err_q, err_d;

    logic        w_op_valid;
    logic        w_div_zero;
    logic        w_timeout;

    assign w_op_valid = (bus.req_op >= 5'd1) && (bus.req_op <= 5'd9);
    assign w_div_zero = (bus.req_op == 5'd4) && (bus.req_y == 32'd0);

`ifdef ALU_SEQ_TIMEOUT_EN
    // Counter is 0 in the first WAIT cycle, so it equals TIMEOUT-1 in the
    // TIMEOUT-th WAIT cycle; the abort takes effect at the end of that cycle.
    localparam logic [9:0] c_TIMEOUT_LAST = 10'(TIMEOUT - 1);

    logic [9:0] cnt_q, cnt_d;

    assign w_timeout = (cnt_q == c_TIMEOUT_LAST);

    // Wait-cycle counter register
    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign w_unused_timeout = ^TIMEOUT;
`endif

    // Next-state and datapath-next computation; everything holds by default
    always_comb begin
        state_d  = state_q;
        alu_op_d = alu_op_q;
        alu_x_d  = alu_x_q;
        alu_y_d  = alu_y_q;
        settle_d = 1'b0;
        res_d    = res_q;
        rem_d    = rem_q;
        err_d    = err_q;
`ifdef ALU_SEQ_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    if (w_op_valid && !w_div_zero) begin
                        state_d  = S_WAIT;
                        alu_op_d = bus.req_op;
                        alu_x_d  = bus.req_x;
                        alu_y_d  = bus.req_y;
                        settle_d = 1'b1;
`ifdef ALU_SEQ_TIMEOUT_EN
                        cnt_d    = '0;
`endif
                    end else begin
                        // Rejected requests never reach the ALU
                        state_d = S_RESP;
                        res_d   = '0;
                        rem_d   = '0;
                        err_d   = 1'b1;
                    end
                end
            end
            S_WAIT: begin
`ifdef ALU_SEQ_TIMEOUT_EN
                cnt_d = cnt_q + 10'd1;
`endif
                // alu_done is not trusted in the settle cycle; a completion
                // takes priority over a simultaneous timeout
                if (!settle_q && bus.alu_done) begin
                    state_d  = S_RESP;
                    res_d    = bus.alu_result;
                    rem_d    = bus.alu_remainder;
                    err_d    = 1'b0;
                    alu_op_d = '0;
                    alu_x_d  = '0;
                    alu_y_d  = '0;
                end else if (w_timeout) begin
                    state_d  = S_RESP;
                    res_d    = '0;
                    rem_d    = '0;
                    err_d    = 1'b1;
                    alu_op_d = '0;
                    alu_x_d  = '0;
                    alu_y_d  = '0;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // ALU drive and response capture registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_op_q <= '0;
            alu_x_q  <= '0;
            alu_y_q  <= '0;
            settle_q <= 1'b0;
            res_q    <= '0;
            rem_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            alu_op_q <= alu_op_d;
            alu_x_q  <= alu_x_d;
            alu_y_q  <= alu_y_d;
            settle_q <= settle_d;
            res_q    <= res_d;
            rem_q    <= rem_d;
            err_q    <= err_d;
        end
    end

    assign bus.req_ready     = (state_q == S_IDLE);
    assign bus.rsp_valid     = (state_q == S_RESP);
    assign bus.alu_op        = alu_op_q;
    assign bus.alu_x         = alu_x_q;
    assign bus.alu_y         = alu_y_q;
    assign bus.rsp_result    = res_q;
    assign bus.rsp_remainder = rem_q;
    assign bus.rsp_err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_sequencer
//  Description : Self-checking bench for alu_sequencer. Expected responses are
//                queued when a request is issued and popped when the DUT
//                presents rsp_valid. Built with TIMEOUT=4; the timeout
//                scenario depends on ALU_SEQ_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

    typedef struct packed {
        logic [66:0] res;
        logic [32:0] rem;
        logic        err;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t sb[$];

    alu_sequencer_if bus ();

    alu_sequencer #(.TIMEOUT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a request for one accepting edge, then drop req_valid
    task automatic issue(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_x     = x;
        bus.req_y     = y;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    // Acts as the ALU from #1 after the accept edge: alu_done is high in WAIT
    // cycles done_from..done_to. Returns the edge offset (after accept) at
    // which rsp_valid rose, or -1 if it never did within max cycles.
    task automatic run_wait(input int done_from, input int done_to,
                            input logic [66:0] res, input logic [32:0] rem,
                            input int max, output int rsp_edge,
                            output logic [4:0] w_op, output logic [31:0] w_x,
                            output logic [31:0] w_y, output bit held);
        rsp_edge = -1;
        held     = 1'b1;
        w_op     = '0;
        w_x      = '0;
        w_y      = '0;
        for (int k = 1; k <= max; k++) begin
            bus.alu_done      = (k >= done_from) && (k <= done_to);
            bus.alu_result    = bus.alu_done ? res : '0;
            bus.alu_remainder = bus.alu_done ? rem : '0;
            @(negedge clk);
            if (bus.rsp_valid) begin
                rsp_edge = k - 1;
                break;
            end
            if (k == 1) begin
                w_op = bus.alu_op;
                w_x  = bus.alu_x;
                w_y  = bus.alu_y;
            end else if (bus.alu_op !== w_op || bus.alu_x !== w_x || bus.alu_y !== w_y) begin
                held = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        bus.alu_done      = 1'b0;
        bus.alu_result    = '0;
        bus.alu_remainder = '0;
    endtask

    // Accept the response currently presented (called at a negedge)
    task automatic drain();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        n_cmp++; if (bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b want 0", bus.rsp_err); end
        n_cmp++; if (bus.rsp_result !== 67'd0) begin n_fail++; $display("FAIL reset_rsp_result: got %0h want 0", bus.rsp_result); end
        n_cmp++; if (bus.rsp_remainder !== 33'd0) begin n_fail++; $display("FAIL reset_rsp_rem: got %0h want 0", bus.rsp_remainder); end
        n_cmp++; if (bus.alu_op !== 5'd0) begin n_fail++; $display("FAIL reset_alu_op: got %0d want 0", bus.alu_op); end
        n_cmp++; if (bus.alu_x !== 32'd0 || bus.alu_y !== 32'd0) begin n_fail++; $display("FAIL reset_alu_xy: got %0h/%0h want 0/0", bus.alu_x, bus.alu_y); end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_add();
        exp_t e; int edge_n; logic [4:0] op; logic [31:0] x, y; bit held;
        sb.push_back({67'd12, 33'd0, 1'b0});
        issue(5'd1, 32'd5, 32'd7);
        run_wait(2, 99, 67'd12, 33'd0, 12, edge_n, op, x, y, held);
        e = sb.pop_front();
        n_cmp++; if (edge_n !== 2) begin n_fail++; $display("FAIL add_latency: got edge %0d want 2", edge_n); end
        n_cmp++; if (op !== 5'd1 || x !== 32'd5 || y !== 32'd7) begin n_fail++; $display("FAIL add_alu_drive: got %0d/%0d/%0d want 1/5/7", op, x, y); end
        n_cmp++; if (!held) begin n_fail++; $display("FAIL add_alu_held: got changing operands want constant"); end
        n_cmp++; if (bus.rsp_result !== e.res || bus.rsp_remainder !== e.rem || bus.rsp_err !== e.err) begin
            n_fail++; $display("FAIL add_rsp: got %0h/%0h/%b want %0h/%0h/%b", bus.rsp_result, bus.rsp_remainder, bus.rsp_err, e.res, e.rem, e.err); end
        n_cmp++; if (bus.alu_op !== 5'd0 || bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL add_resp_state: got alu_op %0d req_ready %b want 0/0", bus.alu_op, bus.req_ready); end
        drain();
        @(negedge clk);
        n_cmp++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL add_drain: got valid %b ready %b want 0/1", bus.rsp_valid, bus.req_ready); end
    endtask

    task automatic test_invalid();
        logic [4:0] ops [2];
        exp_t e;
        ops[0] = 5'd0;
        ops[1] = 5'd12;
        for (int i = 0; i < 2; i++) begin
            sb.push_back({67'd0, 33'd0, 1'b1});
            issue(ops[i], 32'd11, 32'd22);
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL inv%0d_rsp_valid: got %b want 1", i, bus.rsp_valid); end
            n_cmp++; if (bus.rsp_result !== e.res || bus.rsp_remainder !== e.rem || bus.rsp_err !== e.err) begin
                n_fail++; $display("FAIL inv%0d_rsp: got %0h/%0h/%b want %0h/%0h/%b", i, bus.rsp_result, bus.rsp_remainder, bus.rsp_err, e.res, e.rem, e.err); end
            n_cmp++; if (bus.alu_op !== 5'd0 || bus.alu_x !== 32'd0) begin n_fail++; $display("FAIL inv%0d_alu_idle: got op %0d x %0h want 0/0", i, bus.alu_op, bus.alu_x); end
            drain();
        end
    endtask

    task automatic test_divide();
        exp_t e; int edge_n; logic [4:0] op; logic [31:0] x, y; bit held;
        sb.push_back({67'd0, 33'd0, 1'b1});
        issue(5'd4, 32'd100, 32'd0);
        @(negedge clk);
        e = sb.pop_front();
        n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== e.err || bus.rsp_result !== e.res || bus.alu_op !== 5'd0) begin
            n_fail++; $display("FAIL div0_rsp: got valid %b err %b res %0h alu_op %0d want 1/%b/%0h/0", bus.rsp_valid, bus.rsp_err, bus.rsp_result, bus.alu_op, e.err, e.res); end
        drain();
        // alu_done is already high in the settle cycle; it must not be taken
        sb.push_back({67'd33, 33'd1, 1'b0});
        issue(5'd4, 32'd100, 32'd3);
        run_wait(1, 3, 67'd33, 33'd1, 12, edge_n, op, x, y, held);
        e = sb.pop_front();
        n_cmp++; if (edge_n !== 2) begin n_fail++; $display("FAIL div_settle_latency: got edge %0d want 2", edge_n); end
        n_cmp++; if (op !== 5'd4 || x !== 32'd100 || y !== 32'd3) begin n_fail++; $display("FAIL div_alu_drive: got %0d/%0d/%0d want 4/100/3", op, x, y); end
        n_cmp++; if (bus.rsp_result !== e.res || bus.rsp_remainder !== e.rem || bus.rsp_err !== e.err) begin
            n_fail++; $display("FAIL div_rsp: got %0h/%0h/%b want %0h/%0h/%b", bus.rsp_result, bus.rsp_remainder, bus.rsp_err, e.res, e.rem, e.err); end
        drain();
    endtask

    task automatic test_backpressure();
        exp_t e; int edge_n; logic [4:0] op; logic [31:0] x, y; bit held;
        sb.push_back({67'h5_DEAD_BEEF_0123_4567, 33'h1_0000_0002, 1'b0});
        issue(5'd2, 32'd3, 32'd4);
        // Upstream already holds the next (invalid) request; it must wait
        bus.req_valid = 1'b1;
        bus.req_op    = 5'd0;
        run_wait(2, 2, 67'h5_DEAD_BEEF_0123_4567, 33'h1_0000_0002, 12, edge_n, op, x, y, held);
        e = sb.pop_front();
        n_cmp++; if (edge_n !== 2) begin n_fail++; $display("FAIL bp_latency: got edge %0d want 2", edge_n); end
        for (int c = 0; c < 5; c++) begin
            n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0 || bus.rsp_result !== e.res || bus.rsp_remainder !== e.rem || bus.rsp_err !== e.err) begin
                n_fail++; $display("FAIL bp_hold%0d: got v%b r%b %0h/%0h/%b want v1 r0 %0h/%0h/%b", c, bus.rsp_valid, bus.req_ready, bus.rsp_result, bus.rsp_remainder, bus.rsp_err, e.res, e.rem, e.err); end
            if (c < 4) begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        drain();
        @(negedge clk);
        n_cmp++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_drain: got valid %b ready %b want 0/1", bus.rsp_valid, bus.req_ready); end
        sb.push_back({67'd0, 33'd0, 1'b1});
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        e = sb.pop_front();
        n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== e.res || bus.rsp_remainder !== e.rem || bus.rsp_err !== e.err) begin
            n_fail++; $display("FAIL bp_next_req: got v%b %0h/%0h/%b want v1 %0h/%0h/%b", bus.rsp_valid, bus.rsp_result, bus.rsp_remainder, bus.rsp_err, e.res, e.rem, e.err); end
        drain();
    endtask

    task automatic test_timeout();
        exp_t e; int edge_n; logic [4:0] op; logic [31:0] x, y; bit held;
`ifdef ALU_SEQ_TIMEOUT_EN
        sb.push_back({67'd0, 33'd0, 1'b1});
        issue(5'd3, 32'd1, 32'd2);
        run_wait(0, 0, 67'd0, 33'd0, 20, edge_n, op, x, y, held);
        e = sb.pop_front();
        n_cmp++; if (edge_n !== 4) begin n_fail++; $display("FAIL to_latency: got edge %0d want 4", edge_n); end
        n_cmp++; if (bus.rsp_result !== e.res || bus.rsp_remainder !== e.rem || bus.rsp_err !== e.err) begin
            n_fail++; $display("FAIL to_rsp: got %0h/%0h/%b want %0h/%0h/%b", bus.rsp_result, bus.rsp_remainder, bus.rsp_err, e.res, e.rem, e.err); end
        drain();
        sb.push_back({67'd55, 33'd0, 1'b0});
        issue(5'd3, 32'd1, 32'd2);
        run_wait(4, 4, 67'd55, 33'd0, 20, edge_n, op, x, y, held);
        e = sb.pop_front();
        n_cmp++; if (edge_n !== 4) begin n_fail++; $display("FAIL to_race_latency: got edge %0d want 4", edge_n); end
        n_cmp++; if (bus.rsp_result !== e.res || bus.rsp_err !== e.err) begin
            n_fail++; $display("FAIL to_race_rsp: got %0h/%b want %0h/%b", bus.rsp_result, bus.rsp_err, e.res, e.err); end
        drain();
`else
        // Without the timeout feature WAIT outlasts TIMEOUT until alu_done
        sb.push_back({67'd55, 33'd0, 1'b0});
        issue(5'd3, 32'd1, 32'd2);
        run_wait(8, 8, 67'd55, 33'd0, 20, edge_n, op, x, y, held);
        e = sb.pop_front();
        n_cmp++; if (edge_n !== 8) begin n_fail++; $display("FAIL noto_latency: got edge %0d want 8", edge_n); end
        n_cmp++; if (!held) begin n_fail++; $display("FAIL noto_alu_held: got changing operands want constant"); end
        n_cmp++; if (bus.rsp_result !== e.res || bus.rsp_err !== e.err) begin
            n_fail++; $display("FAIL noto_rsp: got %0h/%b want %0h/%b", bus.rsp_result, bus.rsp_err, e.res, e.err); end
        drain();
`endif
    endtask

    task automatic test_reset_wait();
        issue(5'd5, 32'd9, 32'd9);
        @(negedge clk);
        n_cmp++; if (bus.alu_op !== 5'd5) begin n_fail++; $display("FAIL rstw_alu_op_wait: got %0d want 5", bus.alu_op); end
        @(posedge clk);
        #1;
        rst_n             = 1'b0;
        bus.alu_done      = 1'b1;
        bus.alu_result    = 67'd99;
        bus.alu_remainder = 33'd7;
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        bus.alu_done  = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.alu_op !== 5'd0 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL rstw_after: got op %0d valid %b ready %b want 0/0/1", bus.alu_op, bus.rsp_valid, bus.req_ready); end
        n_cmp++; if (bus.rsp_result !== 67'd0 || bus.rsp_remainder !== 33'd0) begin
            n_fail++; $display("FAIL rstw_cleared: got %0h/%0h want 0/0", bus.rsp_result, bus.rsp_remainder); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstw_no_rsp%0d: got %b want 0", c, bus.rsp_valid); end
        end
        n_cmp++; if (sb.size() !== 0) begin n_fail++; $display("FAIL scoreboard_left: got %0d entries want 0", sb.size()); end
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.req_valid     = 1'b0;
        bus.req_op        = '0;
        bus.req_x         = '0;
        bus.req_y         = '0;
        bus.alu_done      = 1'b0;
        bus.alu_result    = '0;
        bus.alu_remainder = '0;
        bus.rsp_ready     = 1'b0;
        test_reset();
        test_add();
        test_invalid();
        test_divide();
        test_backpressure();
        test_timeout();
        test_reset_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test want completion within 100000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
